// File: rtl/sgd_dot_product_accum.sv
// sgd_dot_product_accum: folds per-beat partial sums from an upstream adder
// tree into one dot product per sample and queues the results in a small
// first-word-fall-through FIFO for a ready/valid consumer.
// Optional build macro: SGD_ACC_SATURATE_EN clamps each accumulation step to
// the signed 32-bit range instead of wrapping.
module sgd_dot_product_accum #(
  parameter int FIFO_DEPTH = 4
) (
  input  logic               clk,
  input  logic               rst_n,
  input  logic               start,
  input  logic [15:0]        num_beats,
  input  logic [31:0]        num_samples,
  input  logic signed [31:0] v_input,
  input  logic               v_input_valid,
  output logic signed [31:0] v_output,
  output logic               v_output_valid,
  input  logic               v_output_ready,
  output logic               done,
  output logic               overflow_err
);
  localparam int PTR_W = $clog2(FIFO_DEPTH);
  localparam int CNT_W = PTR_W + 1;

  typedef enum logic [0:0] {IDLE, ACCUM} state_t;
  state_t state_reg, state_next;

  logic [15:0]        beats_reg;
  logic [31:0]        samples_reg;
  logic [15:0]        beat_cnt_reg;
  logic [31:0]        sample_cnt_reg;
  logic signed [31:0] acc_reg;
  logic               done_reg;
  logic               overflow_reg;

  logic signed [31:0] mem [FIFO_DEPTH];
  logic [PTR_W-1:0]   wr_ptr_reg;
  logic [PTR_W-1:0]   rd_ptr_reg;
  logic [CNT_W-1:0]   count_reg;

  logic               start_ok;
  logic               beat_en;
  logic               first_beat;
  logic               last_beat;
  logic               last_sample;
  logic signed [31:0] add_res;
  logic signed [31:0] sum_next;
  logic               fifo_full;
  logic               pop;
  logic               wr_try;
  logic               wr_ok;
  logic               drop;

  assign first_beat  = (beat_cnt_reg == 16'd0);
  assign last_beat   = (beat_cnt_reg == beats_reg - 16'd1);
  assign last_sample = (sample_cnt_reg == samples_reg - 32'd1);

`ifdef SGD_ACC_SATURATE_EN
  logic signed [32:0] wide_sum;
  assign wide_sum = {acc_reg[31], acc_reg} + {v_input[31], v_input};

  // Clamp when the two top bits of the widened sum disagree (signed overflow).
  always_comb begin
    add_res = wide_sum[31:0];
    if (wide_sum[32] != wide_sum[31]) begin
      add_res = wide_sum[32] ? 32'sh8000_0000 : 32'sh7FFF_FFFF;
    end
  end
`else
  assign add_res = acc_reg + v_input;
`endif

  assign sum_next = first_beat ? v_input : add_res;

  assign fifo_full = (count_reg == CNT_W'(FIFO_DEPTH));
  assign pop       = v_output_valid && v_output_ready;
  assign wr_try    = beat_en && last_beat;
  assign wr_ok     = wr_try && (!fifo_full || pop);
  assign drop      = wr_try && !wr_ok;

  // Next-state logic: start only matters in IDLE, beats only in ACCUM.
  always_comb begin
    state_next = state_reg;
    start_ok   = 1'b0;
    beat_en    = 1'b0;
    case (state_reg)
      IDLE: begin
        if (start) begin
          start_ok   = 1'b1;
          state_next = ACCUM;
        end
      end
      ACCUM: begin
        if (v_input_valid) begin
          beat_en = 1'b1;
          if (last_beat && last_sample) begin
            state_next = IDLE;
          end
        end
      end
      default: state_next = IDLE;
    endcase
  end

  // Control state, job counters, accumulator and FIFO bookkeeping.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_reg      <= IDLE;
      beats_reg      <= 16'd1;
      samples_reg    <= 32'd1;
      beat_cnt_reg   <= 16'd0;
      sample_cnt_reg <= 32'd0;
      acc_reg        <= '0;
      done_reg       <= 1'b0;
      overflow_reg   <= 1'b0;
      wr_ptr_reg     <= '0;
      rd_ptr_reg     <= '0;
      count_reg      <= '0;
    end else begin
      state_reg <= state_next;
      done_reg  <= beat_en && last_beat && last_sample;
      if (start_ok) begin
        beats_reg      <= (num_beats == 16'd0) ? 16'd1 : num_beats;
        samples_reg    <= (num_samples == 32'd0) ? 32'd1 : num_samples;
        beat_cnt_reg   <= 16'd0;
        sample_cnt_reg <= 32'd0;
        overflow_reg   <= 1'b0;
      end else if (beat_en) begin
        acc_reg <= sum_next;
        if (last_beat) begin
          beat_cnt_reg   <= 16'd0;
          sample_cnt_reg <= last_sample ? 32'd0 : sample_cnt_reg + 32'd1;
        end else begin
          beat_cnt_reg <= beat_cnt_reg + 16'd1;
        end
      end
      if (drop) begin
        overflow_reg <= 1'b1;
      end
      if (wr_ok) begin
        wr_ptr_reg <= wr_ptr_reg + PTR_W'(1);
      end
      if (pop) begin
        rd_ptr_reg <= rd_ptr_reg + PTR_W'(1);
      end
      if (wr_ok && !pop) begin
        count_reg <= count_reg + CNT_W'(1);
      end else if (pop && !wr_ok) begin
        count_reg <= count_reg - CNT_W'(1);
      end
    end
  end

  // Result storage; contents are don't-care while the entry is unoccupied.
  always_ff @(posedge clk) begin
    if (wr_ok) begin
      mem[wr_ptr_reg] <= sum_next;
    end
  end

  assign v_output_valid = (count_reg != '0);
  assign v_output       = v_output_valid ? mem[rd_ptr_reg] : 32'sd0;
  assign done           = done_reg;
  assign overflow_err   = overflow_reg;

endmodule

// File: tb/tb_sgd_dot_product_accum.sv
// tb_sgd_dot_product_accum: directed scenarios plus randomized jobs, checked
// cycle by cycle against a queue-based reference of the expected result
// stream, the done pulse and the sticky overflow flag.
module tb_sgd_dot_product_accum;
  localparam int FIFO_DEPTH = 4;

  logic               clk;
  logic               rst_n;
  logic               start;
  logic [15:0]        num_beats;
  logic [31:0]        num_samples;
  logic signed [31:0] v_input;
  logic               v_input_valid;
  logic signed [31:0] v_output;
  logic               v_output_valid;
  logic               v_output_ready;
  logic               done;
  logic               overflow_err;

  int tests = 0;
  int fails = 0;

  // Reference state: expected FIFO contents and job progress.
  logic [31:0] mq[$];
  logic [31:0] dq[$];
  bit          m_active = 0;
  bit          m_ovf = 0;
  bit          m_done = 0;
  longint      m_nb = 1;
  longint      m_ns = 1;
  longint      m_k = 0;
  logic [31:0] m_acc = 0;

  sgd_dot_product_accum #(.FIFO_DEPTH(FIFO_DEPTH)) dut (
    .clk(clk), .rst_n(rst_n), .start(start), .num_beats(num_beats),
    .num_samples(num_samples), .v_input(v_input), .v_input_valid(v_input_valid),
    .v_output(v_output), .v_output_valid(v_output_valid),
    .v_output_ready(v_output_ready), .done(done), .overflow_err(overflow_err)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    tests++;
    assert (got === exp) else begin
      fails++;
      $error("FAIL %s: observed %0h expected %0h at %0t", tag, got, exp, $time);
    end
  endtask

  // One accumulation step as arithmetic on true integers.
  function automatic logic [31:0] madd(input logic [31:0] a, input logic [31:0] b);
    longint s;
    s = longint'($signed(a)) + longint'($signed(b));
`ifdef SGD_ACC_SATURATE_EN
    if (s > 64'sh7FFF_FFFF) s = 64'sh7FFF_FFFF;
    else if (s < -64'sh8000_0000) s = -64'sh8000_0000;
`endif
    return s[31:0];
  endfunction

  task automatic check_outputs(input string where);
    chk({where, ".valid"}, {31'd0, v_output_valid}, {31'd0, mq.size() != 0});
    chk({where, ".data"}, v_output, (mq.size() != 0) ? mq[0] : 32'd0);
    chk({where, ".done"}, {31'd0, done}, {31'd0, m_done});
    chk({where, ".ovf"}, {31'd0, overflow_err}, {31'd0, m_ovf});
  endtask

  // Drive one clock of inputs, advance the reference, then check after the edge.
  task automatic cycle(input logic s, input logic vv, input logic [31:0] vi, input logic rdy);
    bit          pop;
    bit          wr;
    bit          nd;
    logic [31:0] wval;
    start = s; v_input_valid = vv; v_input = vi; v_output_ready = rdy;
    pop = (mq.size() != 0) && rdy;
    wr = 0; nd = 0; wval = 0;
    if (!m_active) begin
      if (s) begin
        m_active = 1;
        m_nb = (num_beats == 16'd0) ? 1 : longint'(num_beats);
        m_ns = (num_samples == 32'd0) ? 1 : longint'(num_samples);
        m_k = 0;
        m_ovf = 0;
      end
    end else if (vv) begin
      m_acc = (m_k % m_nb == 0) ? vi : madd(m_acc, vi);
      if (m_k % m_nb == m_nb - 1) begin
        wr = 1;
        wval = m_acc;
      end
      m_k++;
      if (m_k == m_nb * m_ns) begin
        m_active = 0;
        nd = 1;
      end
    end
    if (wr && mq.size() == FIFO_DEPTH && !pop) begin
      m_ovf = 1;
      wr = 0;
    end
    @(posedge clk);
    #1;
    if (pop) void'(mq.pop_front());
    if (wr) mq.push_back(wval);
    m_done = nd;
    check_outputs("cyc");
  endtask

  task automatic launch(input logic [15:0] nb, input logic [31:0] ns, input logic rdy);
    num_beats = nb;
    num_samples = ns;
    cycle(1'b1, 1'b0, 32'd0, rdy);
  endtask

  // Stream the queued beats back-to-back.
  task automatic feed(input logic rdy);
    while (dq.size() != 0) cycle(1'b0, 1'b1, dq.pop_front(), rdy);
  endtask

  task automatic drain();
    int budget = 50;
    while (mq.size() != 0 && budget > 0) begin
      cycle(1'b0, 1'b0, 32'd0, 1'b1);
      budget--;
    end
    chk("drain_empty", {31'd0, v_output_valid}, 32'd0);
  endtask

  task automatic apply_reset();
    start = 0; v_input_valid = 0; v_output_ready = 0;
    rst_n = 1'b0;
    #2;
    mq.delete();
    m_active = 0; m_ovf = 0; m_done = 0;
    check_outputs("reset");
    #2;
    rst_n = 1'b1;
  endtask

  initial begin
    int budget;
    rst_n = 1'b0; start = 0; num_beats = 0; num_samples = 0;
    v_input = 0; v_input_valid = 0; v_output_ready = 0;
    #2;
    check_outputs("por");
    #4;
    rst_n = 1'b1;

    // Valid beats while idle are ignored.
    cycle(1'b0, 1'b1, 32'd77, 1'b0);

    // Three beats per sample, two samples: expect 6 then 7.
    launch(16'd3, 32'd2, 1'b0);
    dq = '{32'd1, 32'd2, 32'd3, -32'sd4, 32'd5, 32'd6};
    feed(1'b0);
    chk("j1.done_pulse", {31'd0, done}, 32'd1);
    chk("j1.head", v_output, 32'd6);
    cycle(1'b0, 1'b0, 32'd0, 1'b1);
    chk("j1.second", v_output, 32'd7);
    drain();

    // num_beats=0 acts as one beat per sample.
    launch(16'd0, 32'd3, 1'b1);
    dq = '{32'd10, -32'sd20, 32'd30};
    feed(1'b1);
    drain();

    // Consumer stalled: fifth result is dropped.
    launch(16'd1, 32'd5, 1'b0);
    dq = '{32'd1, 32'd2, 32'd3, 32'd4, 32'd5};
    feed(1'b0);
    chk("j3.ovf", {31'd0, overflow_err}, 32'd1);
    chk("j3.done", {31'd0, done}, 32'd1);
    chk("j3.head", v_output, 32'd1);
    drain();
    chk("j3.ovf_sticky", {31'd0, overflow_err}, 32'd1);

    // Signed overflow of the accumulator.
    launch(16'd2, 32'd1, 1'b0);
    chk("j4.ovf_cleared", {31'd0, overflow_err}, 32'd0);
    dq = '{32'h7FFF_FFFF, 32'd1};
    feed(1'b0);
    cycle(1'b0, 1'b0, 32'd0, 1'b0);
`ifdef SGD_ACC_SATURATE_EN
    chk("j4.sat", v_output, 32'h7FFF_FFFF);
`else
    chk("j4.wrap", v_output, 32'h8000_0000);
`endif
    drain();

    // Reset in the middle of a job, then a fresh job.
    launch(16'd4, 32'd1, 1'b0);
    dq = '{32'd100, 32'd200};
    feed(1'b0);
    apply_reset();
    cycle(1'b0, 1'b1, 32'd55, 1'b0);
    launch(16'd1, 32'd1, 1'b0);
    dq = '{32'd9};
    feed(1'b0);
    cycle(1'b0, 1'b0, 32'd0, 1'b0);
    chk("j5.nine", v_output, 32'd9);
    drain();

    // Full FIFO popped in the same cycle a result completes.
    launch(16'd1, 32'd5, 1'b0);
    dq = '{32'd11, 32'd12, 32'd13, 32'd14};
    feed(1'b0);
    cycle(1'b0, 1'b1, 32'd15, 1'b1);
    chk("j6.no_ovf", {31'd0, overflow_err}, 32'd0);
    chk("j6.head", v_output, 32'd12);
    drain();

    // Randomized jobs with bursty valid, random ready and stray starts.
    for (int j = 0; j < 30; j++) begin
      launch(16'($urandom_range(0, 4)), 32'($urandom_range(0, 5)), 1'($urandom_range(0, 1)));
      budget = 500;
      while (m_active && budget > 0) begin
        logic [31:0] d;
        d = ($urandom_range(0, 3) == 0)
            ? (($urandom_range(0, 1) != 0 ? 32'h7FFF_FFFF : 32'h8000_0000) ^ 32'($urandom_range(0, 15)))
            : $urandom;
        cycle(1'($urandom_range(0, 7) == 0), 1'($urandom_range(0, 3) != 0), d,
              1'($urandom_range(0, 2) != 0));
        budget--;
      end
      tests++;
      assert (!m_active) else begin
        fails++;
        $error("FAIL job_timeout: job %0d observed still active expected finished", j);
      end
      for (int i = 0; i < 3; i++)
        cycle(1'b0, 1'($urandom_range(0, 1)), $urandom, 1'($urandom_range(0, 2) != 0));
    end
    drain();

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end
endmodule

// File: doc/sgd_dot_product_accum.md
SGD_DOT_PRODUCT_ACCUM -- requirements
Module: sgd_dot_product_accum

Interface
REQ-001 SHALL have parameter FIFO_DEPTH, default 4, result FIFO entries (power of two, >=2).
REQ-002 SHALL have port clk  input  1  sole clock, rising edge.
REQ-003 SHALL have port rst_n  input  1  reset, asynchronous, active-low.
REQ-004 SHALL have port start  input  1  single-cycle pulse launching a job; honoured in IDLE only.
REQ-005 SHALL have port num_beats  input  16  partial sums per sample, sampled on start.
REQ-006 SHALL have port num_samples  input  32  samples per job, sampled on start.
REQ-007 SHALL have port v_input  input  32 signed  partial sum from the upstream adder tree.
REQ-008 SHALL have port v_input_valid  input  1  v_input qualifier; no backpressure upstream.
REQ-009 SHALL have port v_output  output  32 signed  completed dot product (FIFO head).
REQ-010 SHALL have port v_output_valid  output  1  FIFO non-empty.
REQ-011 SHALL have port v_output_ready  input  1  consumer accepts head when high with valid.
REQ-012 SHALL have port done  output  1  one-cycle pulse when the last sample's result is written.
REQ-013 SHALL have port overflow_err  output  1  sticky; a result was dropped because the FIFO was full.

Function
REQ-014 SHALL implement FSM states IDLE and ACCUM; start in IDLE -> ACCUM, last beat of last sample -> IDLE.
REQ-015 SHALL treat num_beats==0 as 1 and num_samples==0 as 1.
REQ-016 SHALL ignore v_input_valid in IDLE and start in ACCUM.
REQ-017 SHALL keep beat counter (0..num_beats-1) and sample counter (0..num_samples-1), advancing only on v_input_valid in ACCUM.
REQ-018 SHALL on first beat of a sample load acc <= v_input; on later beats acc <= acc + v_input.
REQ-019 SHALL on last beat write acc+v_input (or v_input if num_beats==1) into the FIFO; v_output_valid asserts the following cycle (latency 1 from last beat).
REQ-020 SHALL present the FIFO first-word-fall-through; pop on v_output_valid & v_output_ready.
REQ-021 SHALL accept a write when full only if a pop occurs the same cycle; otherwise drop the result, set overflow_err, still advance counters.
REQ-022 SHALL, on simultaneous write and pop when empty, write the FIFO and leave occupancy 1 (no bypass).
REQ-023 SHALL assert done in the cycle after the final write attempt, even if dropped.
REQ-024 SHALL hold overflow_err until reset or the next start.
REQ-025 SHALL allow start in the same cycle the FSM returns to IDLE to be honoured on the next cycle only.

Reset
REQ-026 SHALL on rst_n low, asynchronously: FSM=IDLE, counters=0, acc=0, FIFO empty, v_output=0, v_output_valid=0, done=0, overflow_err=0.
REQ-027 SHALL discard any partial sample and all FIFO contents if reset occurs mid-job.

Configuration
REQ-028 SHALL, with SGD_ACC_SATURATE_EN defined, clamp each accumulation to [-2^31, 2^31-1] using a 33-bit intermediate.
REQ-029 SHALL, without SGD_ACC_SATURATE_EN, wrap accumulation in 32-bit two's complement.

Verification
REQ-030 SHALL cover: start num_beats=3 num_samples=2, inputs 1,2,3,-4,5,6 -> outputs 6 then 7, done one cycle after beat 6.
REQ-031 SHALL cover: num_beats=0 num_samples=3, inputs 10,-20,30 -> outputs 10,-20,30, each valid one cycle after input.
REQ-032 SHALL cover: ready=0, num_beats=1 num_samples=5, inputs 1..5 -> FIFO holds 1..4, 5 dropped, overflow_err=1, done pulses.
REQ-033 SHALL cover: num_beats=2, inputs 0x7FFFFFFF,1 -> 0x7FFFFFFF with SGD_ACC_SATURATE_EN, 0x80000000 without.
REQ-034 SHALL cover: rst_n low after beat 2 of num_beats=4 -> all outputs zero, FSM IDLE; new job num_beats=1 input 9 -> output 9.
REQ-035 SHALL cover: FIFO full, ready=1 in the same cycle as a completing sample -> head popped, new result written, overflow_err stays 0.
